// File: rtl/aq_djpeg_pkg.sv
// rtl/aq_djpeg_pkg.sv - shared pixel-size constants, FIFO entry layout and write-FSM encoding
// AQ_DJPEG_PIXWR_RGB565_EN selects 16-bit RGB565 packing instead of 32-bit XRGB.
package aq_djpeg_pkg;

    localparam int BPP_XRGB = 4;
    localparam int BPP_565  = 2;
    localparam int ENTRY_W  = 68;

`ifdef AQ_DJPEG_PIXWR_RGB565_EN
    localparam bit RGB565_EN = 1'b1;
`else
    localparam bit RGB565_EN = 1'b0;
`endif

    localparam logic [31:0] PIX_BPP = RGB565_EN ? 32'(BPP_565) : 32'(BPP_XRGB);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_entry_t;

    function automatic wr_entry_t pack_pixel(input logic [31:0] addr,
                                             input logic [7:0]  r,
                                             input logic [7:0]  g,
                                             input logic [7:0]  b);
        wr_entry_t   e;
        logic [15:0] p565;
        p565   = {r[7:3], g[7:2], b[7:3]};
        e.addr = addr;
        if (RGB565_EN) begin
            // Both halves carry the pixel; the byte enables pick the live one.
            e.data = {p565, p565};
            e.be   = addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            e.data = {8'h00, r, g, b};
            e.be   = 4'hF;
        end
        return e;
    endfunction

endpackage

// File: rtl/aq_djpeg_pixwr_fifo.sv
// rtl/aq_djpeg_pixwr_fifo.sv - synchronous FIFO with registered head entry
// Also exports the next-cycle non-empty flag so the request FSM can hit 1-cycle latency.
module aq_djpeg_pixwr_fifo
    import aq_djpeg_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               nonempty_d_o
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] head_q, head_d;
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nx;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        empty_o   = (count_q == '0);
        full_o    = (count_q == (FIFO_AW+1)'(DEPTH));
        do_pop    = pop_i && !empty_o;
        do_push   = push_i && (!full_o || do_pop);
        rd_ptr_nx = rd_ptr_q + FIFO_AW'(1);

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (FIFO_AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (FIFO_AW+1)'(1);
        end

        // The head register must always mirror the oldest live entry.
        head_d = head_q;
        if (do_pop) begin
            head_d = (count_q == (FIFO_AW+1)'(1) && do_push) ? wdata_i : mem_q[rd_ptr_nx];
        end else if (empty_o && do_push) begin
            head_d = wdata_i;
        end

        head_o       = head_q;
        nonempty_d_o = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/aq_djpeg_pixwr.sv
// rtl/aq_djpeg_pixwr.sv - JPEG pixel write-back: clip, pack, queue and write to a linear frame buffer
// Build option AQ_DJPEG_PIXWR_RGB565_EN (see aq_djpeg_pkg) switches to RGB565 pixels.
module aq_djpeg_pixwr
    import aq_djpeg_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        InIdle,
    input  logic        InEnable,
    input  logic [15:0] InWidth,
    input  logic [15:0] InHeight,
    input  logic [15:0] InPixelX,
    input  logic [15:0] InPixelY,
    input  logic [7:0]  InR,
    input  logic [7:0]  InG,
    input  logic [7:0]  InB,
    input  logic [31:0] FrameBase,
    input  logic [15:0] FrameStride,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [31:0] MemData,
    output logic [3:0]  MemBe,
    input  logic        MemAck,
    output logic        Overflow,
    input  logic        OverflowClr,
    output logic        FrameDone,
    output logic        Busy
);

    wr_state_e   state_q, state_d;
    logic        idle_q, done_q, ovf_q;
    logic [31:0] base_q, base_eff, pix_cnt_q, frame_px, pix_addr;
    logic [15:0] stride_q, stride_eff;
    logic        in_img, mem_pop, push, drop;
    logic        fifo_empty, fifo_full, fifo_nonempty_d;
    wr_entry_t   wr_entry, head_e;
    logic [ENTRY_W-1:0] fifo_head;

    always_comb begin
        // A strobe in the very cycle InIdle falls must already see the new base/stride.
        base_eff   = (idle_q && !InIdle) ? FrameBase   : base_q;
        stride_eff = (idle_q && !InIdle) ? FrameStride : stride_q;
        in_img     = InEnable && (InPixelX < InWidth) && (InPixelY < InHeight);
        mem_pop    = (state_q == ST_REQ) && MemAck;
        push       = in_img && (!fifo_full || mem_pop);
        drop       = in_img && !push;
        pix_addr   = base_eff + {16'h0, InPixelY} * {16'h0, stride_eff}
                              + {16'h0, InPixelX} * PIX_BPP;
        wr_entry   = pack_pixel(pix_addr, InR, InG, InB);
        frame_px   = {16'h0, InWidth} * {16'h0, InHeight};
        head_e     = fifo_head;
    end

    aq_djpeg_pixwr_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .wdata_i      (wr_entry),
        .pop_i        (mem_pop),
        .head_o       (fifo_head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .nonempty_d_o (fifo_nonempty_d)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        MemReq  = 1'b0;
        MemAddr = '0;
        MemData = '0;
        MemBe   = '0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_nonempty_d) state_d = ST_REQ;
            end
            ST_REQ: begin
                MemReq  = 1'b1;
                MemAddr = head_e.addr;
                MemData = head_e.data;
                MemBe   = head_e.be;
                if (MemAck && !fifo_nonempty_d) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Overflow  = ovf_q;
        Busy      = !fifo_empty || MemReq;
        FrameDone = !InIdle && !done_q && (frame_px != '0) && (pix_cnt_q == frame_px)
                    && fifo_empty && !MemReq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= 1'b1;
            base_q    <= '0;
            stride_q  <= '0;
            pix_cnt_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            idle_q   <= InIdle;
            base_q   <= base_eff;
            stride_q <= stride_eff;
            if (InIdle)      pix_cnt_q <= '0;
            else if (in_img) pix_cnt_q <= pix_cnt_q + 32'd1;
            if (InIdle)         done_q <= 1'b0;
            else if (FrameDone) done_q <= 1'b1;
            if (drop)             ovf_q <= 1'b1;
            else if (OverflowClr) ovf_q <= 1'b0;
        end
    end

endmodule

// File: doc/aq_djpeg_pixwr.md
# aq_djpeg_pixwr

Pixel write-back stage downstream of the JPEG decoder top level. Accepts the decoder's per-pixel strobe (enable, X/Y, R/G/B, image width/height), clips MCU padding outside the image, packs each pixel into a memory word, and writes it to a linear frame buffer through a req/ack memory port. A small FIFO absorbs memory stalls, because the decoder output has no back-pressure. A sticky flag reports any pixel lost to FIFO overflow.

## Interface
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- InIdle  in  1  decoder idle (1 = idle); while high, frame counters clear; FIFO and memory side keep draining.
- InEnable  in  1  pixel strobe, one pixel per cycle max.
- InWidth, InHeight  in  16 each  image size in pixels, stable while InIdle = 0.
- InPixelX, InPixelY  in  16 each  pixel coordinate.
- InR, InG, InB  in  8 each  pixel colour.
- FrameBase  in  32  byte address of pixel (0,0); sampled when InIdle falls.
- FrameStride  in  16  bytes per line; sampled when InIdle falls.
- MemReq  out  1  write request.
- MemAddr  out  32  byte address (word-aligned to the pixel size).
- MemData  out  32  write data.
- MemBe  out  4  byte enables.
- MemAck  in  1  request accepted this cycle.
- Overflow  out  1  sticky: an in-image pixel was dropped.
- OverflowClr  in  1  clears Overflow. A set in the same cycle wins.
- FrameDone  out  1  one-cycle pulse when the frame is fully written.
- Busy  out  1  FIFO non-empty or MemReq high.

## Operation
- Clip: a pixel is in-image iff InPixelX < InWidth and InPixelY < InHeight. Out-of-image strobes are ignored entirely: no FIFO write, no count.
- Address, computed at FIFO write: FrameBase + InPixelY*FrameStride + InPixelX*BPP, with BPP = 4 (or 2, see Configuration).
  - Unsigned arithmetic, 32-bit result; wraps modulo 2**32.
  - The FIFO entry holds {addr[31:0], data[31:0], be[3:0]}.
- Pixel packing (default): MemData = {8'h00, R, G, B}; MemBe = 4'hF.
- Write path:
  - An in-image strobe with the FIFO not full pushes one entry.
  - An in-image strobe with the FIFO full is dropped and sets Overflow.
  - Both push and drop increment PixCount, a 32-bit counter.
- Memory FSM, states IDLE and REQ:
  - IDLE -> REQ when the FIFO is non-empty. MemReq/MemAddr/MemData/MemBe are driven from the FIFO head.
  - REQ: the outputs hold stable until MemAck. On MemAck the FIFO pops.
  - After MemAck: stay in REQ if the FIFO still holds an entry after the pop (back-to-back, one word per cycle with MemAck tied high). Otherwise go to IDLE.
- Simultaneous FIFO push and pop are allowed when full: the pop frees a slot and the push succeeds, with no overflow.
- FrameDone:
  - Pulses once when InIdle = 0, PixCount == InWidth*InHeight (32-bit product), the FIFO is empty, and MemReq = 0.
  - A done flag blocks further pulses until InIdle returns high.
  - Width or height of 0 never produces FrameDone.
- InIdle high: clears PixCount and the done flag. It does not flush the FIFO.
- Reset values: MemReq 0, MemAddr 0, MemData 0, MemBe 0, Overflow 0, FrameDone 0, Busy 0; FIFO empty; FSM in IDLE.
- Reset mid-transfer: MemReq drops at the next edge without an ack. The memory side must tolerate an abandoned request.

## Timing
- The FIFO write occurs on the edge ending the strobe cycle (cycle n).
- MemReq is first high in cycle n+1 (registered FIFO head); pixel-to-request latency is 1 cycle from an empty FIFO.
- Sustained throughput is 1 pixel/cycle with MemAck held high.
- FrameDone is asserted in the cycle after the final MemAck.
- Overflow rises the cycle after the dropped strobe.

## Configuration
- AQ_DJPEG_PIXWR_RGB565_EN defined:
  - BPP = 2; pixel = {R[7:3], G[7:2], B[7:3]}, replicated in both MemData halves.
  - MemAddr is the full byte address.
  - MemBe = 4'b0011 when addr[1] = 0, 4'b1100 when addr[1] = 1.
- Not defined: 32-bit XRGB with BPP = 4, MemBe = 4'hF.

## Structure
- Shared package aq_djpeg_pkg holds:
  - pixel-size constants BPP_XRGB = 4 and BPP_565 = 2;
  - FIFO entry width 68;
  - FSM state encoding (IDLE, REQ).
- One sub-module: aq_djpeg_pixwr_fifo, a synchronous FIFO with full/empty flags, a registered head, and parameter FIFO_AW.

## Test plan
- Basic write: W=2, H=2, base 0x1000, stride 8, MemAck tied 1, four pixels.
  - Writes go to 0x1000, 0x1004, 0x1008, 0x100C, with data {00,R,G,B} and MemBe F.
  - FrameDone pulses once, the cycle after the 4th ack.
- Clip: W=3, H=1, strobes at X=0..7, Y=0..1.
  - Exactly 3 writes occur; FrameDone pulses.
- Stall: MemAck held 0 for 20 cycles while 16 in-image pixels arrive (FIFO_AW=4).
  - All 16 are queued; Overflow stays 0; MemAddr/MemData stay stable during the stall.
  - The 17th pixel sets Overflow.
  - OverflowClr then clears it, unless an overflow occurs in the same cycle.
- Full with simultaneous pop: FIFO full, MemAck=1 in the same cycle as a strobe.
  - The push is accepted; Overflow stays 0.
- Wrap: base 0xFFFF_FFF8, stride 16, pixel (0,1).
  - MemAddr = 0x0000_0008.
- Reset during REQ with MemAck=0, then RGB565 build:
  - After reset, MemReq is 0 and the FIFO is empty.
  - RGB565 build: pixel X=1 at base 0 gives addr 2, MemBe 4'b1100, and R=FF,G=00,B=FF packs to 0xF81F in both halves.
